// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed, byte-enabled word memory for the MEM stage.
// Registered read path, req/ready handshake, range/alignment error pulse.
// Optional zero-fill sweep after reset when DATAMEM_CLEAR_EN is defined.
module data_mem_ctrl #(
  parameter int                DATA_W = 32,
  parameter int                DEPTH  = 256,
  parameter int                ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  ready,
  output logic                  rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  err,
  output logic                  busy
);

  localparam int                NB         = DATA_W / 8;
  localparam int                LSB        = $clog2(NB);
  localparam int                IDX_W      = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(NB - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] word_idx;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              aligned;
  logic              valid;
  logic              accept;
  logic              wr_en;

  // Address decode: word index, range and alignment checks, handshake.
  always_comb begin
    off      = addr - BASE;
    word_idx = off >> LSB;
    idx      = word_idx[IDX_W-1:0];
    in_range = (addr >= BASE) && (word_idx < DEPTH_A);
    aligned  = (addr & ALIGN_MASK) == '0;
    valid    = in_range && aligned;
    accept   = req && ready && !reset;
    wr_en    = accept && we && valid;
  end

`ifdef DATAMEM_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] ptr;
  logic             clr_we;

  // State register: reset always restarts the sweep.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_CLEAR;
    else       state <= state_nxt;
  end

  // Next state: leave CLEAR once the last word has been written.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (ptr == IDX_W'(DEPTH - 1)) state_nxt = ST_IDLE;
      ST_IDLE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  // FSM outputs: busy for the whole sweep, one clear write per cycle.
  always_comb begin
    busy   = (state == ST_CLEAR);
    clr_we = busy && !reset;
  end

  // Sweep pointer advances one word per CLEAR cycle.
  always_ff @(posedge clk) begin
    if (reset)                  ptr <= '0;
    else if (state == ST_CLEAR) ptr <= ptr + IDX_W'(1);
  end
`else
  assign busy = 1'b0;
`endif

  assign ready = ~busy;

  // Array write port: sweep clears take priority, otherwise byte-lane merge.
  always_ff @(posedge clk) begin
`ifdef DATAMEM_CLEAR_EN
    if (clr_we) mem[ptr] <= '0;
    else
`endif
    if (wr_en) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Response register: rvalid/err pulse one cycle after acceptance, rdata
  // holds until the next read response.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= accept && !we;
      err    <= accept && !valid;
      if (accept && !we) rdata <= valid ? mem[idx] : '0;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed bench for data_mem_ctrl. One instance at
// BASE=0, one at BASE=0x1000; both share the request inputs.
// Sweep checks run only when DATAMEM_CLEAR_EN is defined.
module tb_data_mem_ctrl;

`ifdef DATAMEM_CLEAR_EN
  localparam logic CLR = 1'b1;
`else
  localparam logic CLR = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  be    = '0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;

  logic        ready0, rvalid0, err0, busy0;
  logic [31:0] rdata0;
  logic        ready1, rvalid1, err1, busy1;
  logic [31:0] rdata1;

  int errors = 0;
  int checks = 0;
  int cnt;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .BASE(32'h0)) dut0 (
    .clk(clk), .reset(reset), .req(req), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .ready(ready0), .rvalid(rvalid0), .rdata(rdata0),
    .err(err0), .busy(busy0)
  );

  data_mem_ctrl #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .BASE(32'h1000)) dut1 (
    .clk(clk), .reset(reset), .req(req), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .ready(ready1), .rvalid(rvalid1), .rdata(rdata1),
    .err(err1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request for one cycle; on return the response of that edge is visible.
  task automatic issue(input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; be = '0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid", rvalid0, 1'b0);
    chk("rst_err",    err0,    1'b0);
    chk("rst_rdata",  rdata0,  32'h0);
    chk("rst_busy",   busy0,   CLR);
    chk("rst_ready",  ready0,  !CLR);

`ifdef DATAMEM_CLEAR_EN
    reset = 1'b0;
    cnt = 0;
    while (busy0 && cnt < 1000) begin idle_cycle(); cnt++; end
    chk("sweep1_len", cnt, 256);
    issue(1'b1, 4'hF, 32'h0,   32'hFFFF_FFFF);
    issue(1'b1, 4'hF, 32'h3FC, 32'hFFFF_FFFF);
    reset = 1'b1; idle_cycle(); reset = 1'b0;
    repeat (100) idle_cycle();
    reset = 1'b1; idle_cycle();
    chk("midrst_busy", busy0, 1'b1);
    reset = 1'b0;
    req = 1'b1; we = 1'b0; addr = 32'h0;
    cnt = 0;
    while (busy0 && cnt < 1000) begin
      idle_cycle(); cnt++;
      chk("busy_noresp", {rvalid0, err0}, 2'b00);
    end
    chk("sweep2_len", cnt, 256);
    chk("sweep2_ready", ready0, 1'b1);
    idle_cycle(); req = 1'b0;
    chk("held_rvalid", rvalid0, 1'b1);
    chk("held_rdata",  rdata0,  32'h0);
    for (int i = 0; i < 256; i++) begin
      issue(1'b0, 4'h0, 32'(i * 4), 32'h0);
      chk("sweep_rd", {rvalid0, err0, rdata0}, {1'b1, 1'b0, 32'h0});
    end
`else
    reset = 1'b0;
    idle_cycle();
    chk("post_rst_busy",   busy0,   1'b0);
    chk("post_rst_ready",  ready0,  1'b1);
    chk("post_rst_rvalid", rvalid0, 1'b0);
`endif

    issue(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    chk("wr_no_resp", {rvalid0, err0}, 2'b00);
    issue(1'b1, 4'b0001, 32'h10, 32'h0000_00AA);
    issue(1'b0, 4'h0, 32'h10, 32'h0);
    chk("merge_rvalid", rvalid0, 1'b1);
    chk("merge_err",    err0,    1'b0);
    chk("merge_rdata",  rdata0,  32'hDEAD_BEAA);
    idle_cycle();
    chk("rvalid_pulse", rvalid0, 1'b0);
    chk("rdata_hold",   rdata0,  32'hDEAD_BEAA);

    issue(1'b1, 4'hF, 32'h0, 32'h1122_3344);
    issue(1'b0, 4'h0, 32'h400, 32'h0);
    chk("oor_rd", {rvalid0, err0, rdata0}, {1'b1, 1'b1, 32'h0});
    issue(1'b0, 4'h0, 32'h0, 32'h0);
    chk("rd0_after_oor", {rvalid0, err0, rdata0}, {1'b1, 1'b0, 32'h1122_3344});
    issue(1'b1, 4'hF, 32'h402, 32'hFFFF_FFFF);
    chk("oor_wr", {rvalid0, err0}, 2'b01);
    issue(1'b1, 4'hF, 32'h2, 32'hFFFF_FFFF);
    chk("misal_wr", {rvalid0, err0}, 2'b01);
    issue(1'b0, 4'h0, 32'h6, 32'h0);
    chk("misal_rd", {rvalid0, err0, rdata0}, {1'b1, 1'b1, 32'h0});
    issue(1'b1, 4'h0, 32'h0, 32'hFFFF_FFFF);
    chk("be0_wr", {rvalid0, err0}, 2'b00);
    issue(1'b0, 4'h0, 32'h0, 32'h0);
    chk("rd0_unchanged", rdata0, 32'h1122_3344);

    issue(1'b1, 4'hF, 32'h4, 32'h5555_6666);
    issue(1'b1, 4'b1100, 32'h4, 32'hABCD_0000);
    issue(1'b1, 4'hF, 32'h8, 32'h7777_8888);
    req = 1'b1; we = 1'b0; addr = 32'h0;
    idle_cycle();
    chk("b2b_0", {ready0, rvalid0, rdata0}, {1'b1, 1'b1, 32'h1122_3344});
    addr = 32'h4;
    idle_cycle();
    chk("b2b_1", {ready0, rvalid0, rdata0}, {1'b1, 1'b1, 32'hABCD_6666});
    addr = 32'h8;
    idle_cycle();
    chk("b2b_2", {ready0, rvalid0, rdata0}, {1'b1, 1'b1, 32'h7777_8888});
    req = 1'b0;
    idle_cycle();
    chk("b2b_end", rvalid0, 1'b0);

    issue(1'b1, 4'hF, 32'h3FC, 32'h0BAD_CAFE);
    chk("last_wr", err0, 1'b0);
    issue(1'b0, 4'h0, 32'h3FC, 32'h0);
    chk("last_rd", {rvalid0, err0, rdata0}, {1'b1, 1'b0, 32'h0BAD_CAFE});

    issue(1'b0, 4'h0, 32'h0FFC, 32'h0);
    chk("base_below", {rvalid1, err1, rdata1}, {1'b1, 1'b1, 32'h0});
    issue(1'b1, 4'hF, 32'h1000, 32'hCAFE_F00D);
    chk("base_wr", {rvalid1, err1}, 2'b00);
    issue(1'b0, 4'h0, 32'h1000, 32'h0);
    chk("base_rd", {rvalid1, err1, rdata1}, {1'b1, 1'b0, 32'hCAFE_F00D});
    issue(1'b0, 4'h0, 32'h10, 32'h0);
    chk("base0_untouched", rdata0, 32'hDEAD_BEAA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
